// File: rtl/nla_job_scheduler.sv
// nla_job_scheduler
//   Shares one polynomial-approximation engine between NUM_REQ requesters.
//   Picks one operand by round-robin arbitration, launches the engine once,
//   waits for completion under a timeout watchdog, and returns a tagged
//   response. Only one job is ever in flight.
//
// Optional feature macro: NLA_SCHED_PRIO_EN
//   defined     : requester 0 has strict priority over the round-robin pool,
//                 and serving it leaves rr_ptr untouched.
//   not defined : pure round-robin across all requesters.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   per-requester request handshake (ready is one-hot)
//   req_data/func     packed operands, slice i belongs to requester i
//   eng_start/abort   one-cycle launch / timeout-abort pulses to the engine
//   eng_data/func     latched operand, held from launch until the response
//   eng_done/result   engine completion pulse and result
//   rsp_*             tagged response (rsp_err=1 means timeout, rsp_data=0)
//   dbg_state         current FSM state (IDLE=0 ISSUE=1 WAIT=2 RESP=3)
//   dbg_spurious_cnt  saturating count of eng_done pulses seen outside WAIT
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A valid source holds its payload until that edge; ready may depend
// combinationally on valid (req_ready does), valid never depends on ready.

module nla_job_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 16,
    parameter int FUNC_W      = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ*FUNC_W-1:0]   req_func,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        eng_start,
    output logic                        eng_abort,
    output logic [DATA_W-1:0]           eng_data,
    output logic [FUNC_W-1:0]           eng_func,
    input  logic                        eng_done,
    input  logic [DATA_W-1:0]           eng_result,
    output logic                        rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        rsp_err,
    input  logic                        rsp_ready,
    output logic [1:0]                  dbg_state,
    output logic [7:0]                  dbg_spurious_cnt
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                eng_start_q, eng_start_d;
    logic                eng_abort_q, eng_abort_d;
    logic [DATA_W-1:0]   eng_data_q, eng_data_d;
    logic [FUNC_W-1:0]   eng_func_q, eng_func_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic [7:0]          spur_cnt_q, spur_cnt_d;

    // Arbitration result
    logic                grant_found;
    logic [ID_W-1:0]     grant_idx;
    logic [DATA_W-1:0]   grant_data;
    logic [FUNC_W-1:0]   grant_func;

    // Rotating search starting at rr_ptr: the first valid requester found
    // wins. With the priority option, requester 0 overrides the rotation.
    always_comb begin
        int cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = int'(rr_ptr_q) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_found && (i == cand) && req_valid[i]) begin
                    grant_found = 1'b1;
                    grant_idx   = ID_W'(i);
                end
            end
        end
`ifdef NLA_SCHED_PRIO_EN
        if (req_valid[0]) begin
            grant_found = 1'b1;
            grant_idx   = '0;
        end
`else
`endif
    end

    // Operand mux for the winner
    always_comb begin
        grant_data = '0;
        grant_func = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                grant_data = req_data[i*DATA_W +: DATA_W];
                grant_func = req_func[i*FUNC_W +: FUNC_W];
            end
        end
    end

    // Ready only in IDLE, one-hot on the winner
    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && grant_found) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_idx == ID_W'(i)) begin
                    req_ready[i] = 1'b1;
                end
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        timer_d     = timer_q;
        eng_start_d = 1'b0;
        eng_abort_d = 1'b0;
        eng_data_d  = eng_data_q;
        eng_func_d  = eng_func_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        spur_cnt_d  = spur_cnt_q;

        // Any completion that arrives while no job is waiting is dropped
        // and only counted.
        if (eng_done && state_q != S_WAIT && spur_cnt_q != 8'hFF) begin
            spur_cnt_d = spur_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (grant_found) begin
                    eng_data_d  = grant_data;
                    eng_func_d  = grant_func;
                    rsp_id_d    = grant_idx;
                    eng_start_d = 1'b1;       // high during the ISSUE cycle
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Timer reads 0 in the launch cycle, so it equals the number
                // of cycles elapsed since eng_start while in WAIT.
                timer_d = timer_q + 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (eng_done) begin
                    // Completion beats the watchdog on the same cycle
                    rsp_data_d  = eng_result;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else if (timer_q == TMR_LAST) begin
                    eng_abort_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
`ifdef NLA_SCHED_PRIO_EN
                    if (rsp_id_q != '0) begin
                        rr_ptr_d = (rsp_id_q == ID_LAST) ? '0 : rsp_id_q + 1'b1;
                    end
`else
                    rr_ptr_d = (rsp_id_q == ID_LAST) ? '0 : rsp_id_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            timer_q     <= '0;
            eng_start_q <= 1'b0;
            eng_abort_q <= 1'b0;
            eng_data_q  <= '0;
            eng_func_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            spur_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            timer_q     <= timer_d;
            eng_start_q <= eng_start_d;
            eng_abort_q <= eng_abort_d;
            eng_data_q  <= eng_data_d;
            eng_func_q  <= eng_func_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            spur_cnt_q  <= spur_cnt_d;
        end
    end

    assign eng_start        = eng_start_q;
    assign eng_abort        = eng_abort_q;
    assign eng_data         = eng_data_q;
    assign eng_func         = eng_func_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_id           = rsp_id_q;
    assign rsp_data         = rsp_data_q;
    assign rsp_err          = rsp_err_q;
    assign dbg_state        = state_q;
    assign dbg_spurious_cnt = spur_cnt_q;

endmodule

// File: tb/tb_nla_job_scheduler.sv
// tb_nla_job_scheduler
//   Directed bench for nla_job_scheduler (NUM_REQ=4, DATA_W=16, FUNC_W=2,
//   TIMEOUT_CYC=64). Inputs are driven on the falling edge; outputs are
//   sampled on the falling edge, or 1 time unit after a drive for the
//   combinational req_ready.

module tb_nla_job_scheduler;

    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int FW   = 2;
    localparam int TOC  = 64;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ*FW-1:0] req_func;
    logic [NREQ-1:0]   req_ready;
    logic              eng_start;
    logic              eng_abort;
    logic [DW-1:0]     eng_data;
    logic [FW-1:0]     eng_func;
    logic              eng_done;
    logic [DW-1:0]     eng_result;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [DW-1:0]     rsp_data;
    logic              rsp_err;
    logic              rsp_ready;
    logic [1:0]        dbg_state;
    logic [7:0]        dbg_spurious_cnt;

    int n_total;
    int n_bad;

    nla_job_scheduler #(
        .NUM_REQ     (NREQ),
        .DATA_W      (DW),
        .FUNC_W      (FW),
        .TIMEOUT_CYC (TOC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_func         (req_func),
        .req_ready        (req_ready),
        .eng_start        (eng_start),
        .eng_abort        (eng_abort),
        .eng_data         (eng_data),
        .eng_func         (eng_func),
        .eng_done         (eng_done),
        .eng_result       (eng_result),
        .rsp_valid        (rsp_valid),
        .rsp_id           (rsp_id),
        .rsp_data         (rsp_data),
        .rsp_err          (rsp_err),
        .rsp_ready        (rsp_ready),
        .dbg_state        (dbg_state),
        .dbg_spurious_cnt (dbg_spurious_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver: one complete job ----------------
    // Called on a falling edge with rsp_ready=1. Presents mask with the
    // generic payload (data 0x1000+i, func i), waits for the grant, plays
    // the engine with completion k cycles after eng_start and checks the
    // response. Returns on the falling edge of the RESP cycle.
    task automatic do_job(input logic [3:0] mask, input int exp_gid, input int k,
                          input logic [15:0] res, input string tag);
        bit got;
        got       = 1'b0;
        req_data  = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        req_func  = {2'd3, 2'd2, 2'd1, 2'd0};
        req_valid = mask;
        for (int w = 0; w < 20; w++) begin
            #1;
            if (req_ready != 4'b0) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            check({tag, "_grant_timeout"}, 32'd0, 32'd1);
            return;
        end
        check({tag, "_grant"}, 32'(req_ready), 32'(4'b0001 << exp_gid));
        @(negedge clk);
        check({tag, "_start"}, 32'(eng_start), 32'd1);
        check({tag, "_eng_data"}, 32'(eng_data), 32'h1000 + 32'(exp_gid));
        check({tag, "_eng_func"}, 32'(eng_func), 32'(exp_gid % 4));
        repeat (k) @(negedge clk);
        eng_done   = 1'b1;
        eng_result = res;
        @(negedge clk);
        eng_done   = 1'b0;
        eng_result = '0;
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'(exp_gid));
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'(res));
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    endtask

    // ---------------- global time limit ----------------
    initial begin
        #100000;
        $display("FAIL time_limit: got=expired exp=finished");
        $fatal(1, "time limit");
    end

    // ---------------- main sequence ----------------
    int exp_ord[8];
    int abort_at;
    bit flag;

    initial begin
        n_total    = 0;
        n_bad      = 0;
        rst        = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        req_func   = '0;
        eng_done   = 1'b0;
        eng_result = '0;
        rsp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // ---- reset values ----
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_eng_start", 32'(eng_start), 32'd0);
        check("rst_eng_abort", 32'(eng_abort), 32'd0);
        check("rst_eng_data", 32'(eng_data), 32'd0);
        check("rst_eng_func", 32'(eng_func), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_spur", 32'(dbg_spurious_cnt), 32'd0);

        // ---- reset in the middle of WAIT ----
        req_data  = {16'h0, 16'h0, 16'h0055, 16'h0};
        req_func  = {2'd0, 2'd0, 2'd2, 2'd0};
        req_valid = 4'b0010;
        #1;
        check("t1_ready", 32'(req_ready), 32'b0010);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        check("t1_start", 32'(eng_start), 32'd1);
        check("t1_eng_data", 32'(eng_data), 32'h55);
        check("t1_eng_func", 32'(eng_func), 32'd2);
        repeat (3) @(negedge clk);
        check("t1_in_wait", 32'(dbg_state), 32'd2);
        rst = 1'b1;
        #1;
        check("t1_rst_state", 32'(dbg_state), 32'd0);
        check("t1_rst_eng_data", 32'(eng_data), 32'd0);
        check("t1_rst_eng_func", 32'(eng_func), 32'd0);
        check("t1_rst_rsp_id", 32'(rsp_id), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid || eng_start || eng_abort) flag = 1'b1;
        end
        check("t1_no_rsp_after", 32'(flag), 32'd0);
        check("t1_idle_after", 32'(dbg_state), 32'd0);

        // ---- single job, then backpressure and spurious done ----
        rsp_ready = 1'b0;
        req_data  = {16'h0, 16'h1234, 16'h0, 16'h0};
        req_func  = {2'd0, 2'd1, 2'd0, 2'd0};
        req_valid = 4'b0100;
        #1;
        check("t2_ready", 32'(req_ready), 32'b0100);
        @(posedge clk);                      // accept, cycle t
        #1;
        req_valid = '0;
        @(negedge clk);                      // cycle t+1
        check("t2_start", 32'(eng_start), 32'd1);
        check("t2_eng_data", 32'(eng_data), 32'h1234);
        check("t2_eng_func", 32'(eng_func), 32'd1);
        flag = 1'b0;
        for (int i = 1; i < 10; i++) begin   // cycles t+2 .. t+10
            @(negedge clk);
            if (eng_start || rsp_valid) flag = 1'b1;
        end
        check("t2_quiet_wait", 32'(flag), 32'd0);
        @(negedge clk);                      // cycle t+11 = start+10
        eng_done   = 1'b1;
        eng_result = 16'hBEEF;
        #1;
        check("t2_no_early_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);                      // cycle t+12
        eng_done   = 1'b0;
        eng_result = '0;
        check("t2_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t2_rsp_id", 32'(rsp_id), 32'd2);
        check("t2_rsp_data", 32'(rsp_data), 32'hBEEF);
        check("t2_rsp_err", 32'(rsp_err), 32'd0);
        check("t2_state_resp", 32'(dbg_state), 32'd3);

        req_data  = {16'h0, 16'h0, 16'h0, 16'h0777};
        req_func  = '0;
        req_valid = 4'b0001;
        flag = 1'b1;
        for (int i = 0; i < 20; i++) begin
            eng_done   = (i == 5);
            eng_result = (i == 5) ? 16'h1111 : 16'h0;
            #1;
            if (!(rsp_valid === 1'b1 && rsp_id === 2'd2 && rsp_data === 16'hBEEF &&
                  rsp_err === 1'b0 && req_ready === 4'b0 && eng_start === 1'b0))
                flag = 1'b0;
            @(negedge clk);
        end
        eng_done   = 1'b0;
        eng_result = '0;
        check("t5_hold_stable", 32'(flag), 32'd1);
        check("t5_spur_resp", 32'(dbg_spurious_cnt), 32'd1);
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t5_rsp_released", 32'(rsp_valid), 32'd0);
        check("t5_back_idle", 32'(dbg_state), 32'd0);
        eng_done   = 1'b1;
        eng_result = 16'h2222;
        @(negedge clk);
        eng_done   = 1'b0;
        eng_result = '0;
        check("t5_spur_idle", 32'(dbg_spurious_cnt), 32'd2);
        check("t5_idle_stays", 32'(dbg_state), 32'd0);
        @(negedge clk);
        check("t5_no_rsp_idle", 32'(rsp_valid), 32'd0);
        check("t5_no_start_idle", 32'(eng_start), 32'd0);

        // ---- timeout (rr_ptr is 3 here, so the search wraps to 0) ----
        req_data  = {16'h0, 16'h0, 16'h0, 16'hAAAA};
        req_func  = {2'd0, 2'd0, 2'd0, 2'd3};
        req_valid = 4'b0001;
        #1;
        check("t4_ready", 32'(req_ready), 32'b0001);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        check("t4_start", 32'(eng_start), 32'd1);
        abort_at = -1;
        for (int i = 1; i <= TOC + 10; i++) begin
            @(negedge clk);
            if (eng_abort) begin
                abort_at = i;
                break;
            end
        end
        check("t4_abort_delay", 32'(abort_at), 32'(TOC));
        check("t4_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t4_rsp_err", 32'(rsp_err), 32'd1);
        check("t4_rsp_data", 32'(rsp_data), 32'd0);
        check("t4_rsp_id", 32'(rsp_id), 32'd0);
        @(negedge clk);
        check("t4_abort_pulse", 32'(eng_abort), 32'd0);
        check("t4_rsp_done", 32'(rsp_valid), 32'd0);
        check("t4_idle", 32'(dbg_state), 32'd0);
        do_job(4'b0100, 2, 2, 16'h0F0F, "t4_next");
        req_valid = '0;
        @(negedge clk);

        // ---- fairness / priority from a fresh rr_ptr ----
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b1;
`ifdef NLA_SCHED_PRIO_EN
        exp_ord = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
        exp_ord = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        for (int j = 0; j < 8; j++) begin
            do_job(4'b1111, exp_ord[j], 3, 16'h5000 + 16'(j), $sformatf("t3_job%0d", j));
        end
        // Requester 0 idle: rotation among the rest in either build
        do_job(4'b1110, 1, 1, 16'h6001, "t6_a");
        do_job(4'b1110, 2, 1, 16'h6002, "t6_b");
        do_job(4'b1110, 3, 1, 16'h6003, "t6_c");
        do_job(4'b1110, 1, 1, 16'h6004, "t6_d");
        req_valid = '0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
